// File: rtl/mips_pkg.sv
// Shared constants for the IF-stage instruction memory: NOP encoding,
// word geometry helper and loader state encoding.
package mips_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

    localparam logic [31:0] NOP_INSTR = '0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian words: first byte lands in bits [7:0].
module byte_packer
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_byte_en,
    input  logic [7:0]            i_byte,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic                  o_word_valid,
    output logic                  o_partial
);

    localparam int unsigned BPW   = bytes_per_word(DATA_WIDTH);
    localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic                  w_last;

    // New bytes enter at the top, so after BPW shifts the first byte sits at [7:0].
    assign w_shifted    = (r_shift >> 8) | (DATA_WIDTH'(i_byte) << (DATA_WIDTH - 8));
    assign w_last       = (r_count == CNT_W'(BPW - 1));
    assign o_word       = w_shifted;
    assign o_word_valid = i_byte_en && w_last;
    assign o_partial    = (r_count != '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
            r_shift <= '0;
        end else if (i_clear) begin
            r_count <= '0;
            r_shift <= '0;
        end else if (i_byte_en) begin
            r_shift <= w_shifted;
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/insmem_loader.sv
// Instruction memory with byte-stream loader, per-word valid bitmap and
// combinational fetch port that returns NOP for unloaded/faulting addresses.
module insmem_loader
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                                            i_clk,
    input  logic                                            i_reset,
    input  logic                                            i_load_start,
    input  logic                                            i_load_valid,
    input  logic [7:0]                                      i_load_byte,
    output logic                                            o_load_ready,
    input  logic                                            i_load_done,
    output logic [$clog2(DEPTH_BYTES/(DATA_WIDTH/8)):0]     o_load_count,
    output logic                                            o_load_full,
    output logic                                            o_load_err,
    output logic                                            o_busy,
    input  logic                                            i_read_en,
    input  logic [ADDR_WIDTH-1:0]                           i_addr,
    output logic [DATA_WIDTH-1:0]                           o_instruction,
    output logic                                            o_fetch_fault
);

    localparam int unsigned BPW    = bytes_per_word(DATA_WIDTH);
    localparam int unsigned NWORDS = DEPTH_BYTES / BPW;
    localparam int unsigned CNT_W  = $clog2(NWORDS) + 1;
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned MEM_AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH_BYTES - BPW);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_wr_idx;
    logic                  r_err;
    logic [NWORDS-1:0]     r_valid;
    logic [7:0]            r_mem [DEPTH_BYTES];

    logic                  w_accept;
    logic                  w_done;
    logic                  w_clear;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_word_valid;
    logic                  w_partial;
    logic [MEM_AW-1:0]     w_wr_base;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic [MEM_AW-1:0]     w_rd_base;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign o_load_ready = (r_state == ST_LOAD) && !i_load_start;
    assign w_accept     = i_load_valid && o_load_ready;
    assign w_done       = i_load_done && !i_load_start && (r_state != ST_IDLE);
    assign w_clear      = i_load_start || w_done;

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_clear),
        .i_byte_en    (w_accept),
        .i_byte       (i_load_byte),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_partial    (w_partial)
    );

    // The word index doubles as the load pointer (byte pointer = index * BPW).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_wr_idx <= '0;
            r_err    <= 1'b0;
            r_valid  <= '0;
        end else if (i_load_start) begin
            r_state  <= ST_LOAD;
            r_wr_idx <= '0;
            r_err    <= 1'b0;
            r_valid  <= '0;
        end else begin
            if (w_word_valid) begin
                r_valid[r_wr_idx[IDX_W-1:0]] <= 1'b1;
                r_wr_idx                     <= r_wr_idx + 1'b1;
                if (r_wr_idx == CNT_W'(NWORDS - 1)) begin
                    r_state <= ST_FULL;
                end
            end
            // A byte arriving with done is counted first; only a leftover partial word errors.
            if (w_done) begin
                r_state <= ST_IDLE;
                if (w_accept ? !w_word_valid : w_partial) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign w_wr_base = MEM_AW'(r_wr_idx * BPW);

    always_ff @(posedge i_clk) begin
        if (w_word_valid) begin
            for (int unsigned b = 0; b < BPW; b++) begin
                r_mem[w_wr_base + MEM_AW'(b)] <= w_word[b*8 +: 8];
            end
        end
    end

    assign o_load_count = r_wr_idx;
    assign o_load_full  = (r_state == ST_FULL);
    assign o_load_err   = r_err;
    assign o_busy       = (r_state != ST_IDLE);

    assign w_misaligned   = (i_addr % ADDR_WIDTH'(BPW)) != '0;
    assign w_out_of_range = (i_addr > LAST_ADDR);
    assign o_fetch_fault  = i_read_en && (w_misaligned || w_out_of_range);

    assign w_rd_base = i_addr[MEM_AW-1:0];
    assign w_rd_idx  = IDX_W'(i_addr / ADDR_WIDTH'(BPW));
    assign w_hit     = i_read_en && (r_state == ST_IDLE) && !w_misaligned
                       && !w_out_of_range && r_valid[w_rd_idx];

    always_comb begin
        w_rd_word = '0;
        for (int unsigned b = 0; b < BPW; b++) begin
            w_rd_word[b*8 +: 8] = r_mem[w_rd_base + MEM_AW'(b)];
        end
    end

    assign o_instruction = w_hit ? w_rd_word : DATA_WIDTH'(NOP_INSTR);

endmodule

// File: tb/tb_insmem_loader.sv
// Scoreboarded bench for insmem_loader: a queue/array reference model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_insmem_loader;

    localparam int DW  = 32;
    localparam int DB  = 1024;
    localparam int AW  = 32;
    localparam int BPW = DW / 8;
    localparam int NW  = DB / BPW;
    localparam int CW  = $clog2(NW) + 1;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_load_start;
    logic          i_load_valid;
    logic [7:0]    i_load_byte;
    logic          o_load_ready;
    logic          i_load_done;
    logic [CW-1:0] o_load_count;
    logic          o_load_full;
    logic          o_load_err;
    logic          o_busy;
    logic          i_read_en;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] o_instruction;
    logic          o_fetch_fault;

    always #5 clk = ~clk;

    insmem_loader #(
        .DATA_WIDTH  (DW),
        .DEPTH_BYTES (DB),
        .ADDR_WIDTH  (AW)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_load_start  (i_load_start),
        .i_load_valid  (i_load_valid),
        .i_load_byte   (i_load_byte),
        .o_load_ready  (o_load_ready),
        .i_load_done   (i_load_done),
        .o_load_count  (o_load_count),
        .o_load_full   (o_load_full),
        .o_load_err    (o_load_err),
        .o_busy        (o_busy),
        .i_read_en     (i_read_en),
        .i_addr        (i_addr),
        .o_instruction (o_instruction),
        .o_fetch_fault (o_fetch_fault)
    );

    typedef struct {
        string         name;
        logic [DW-1:0] instr;
        logic          fault;
        logic [CW-1:0] count;
        logic          err;
        logic          full;
        logic          busy;
        logic          ready;
    } exp_t;

    exp_t sb[$];
    logic chk = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: mode 0 = idle, 1 = loading, 2 = full.
    int            m_mode;
    int            m_count;
    bit            m_err;
    logic [DW-1:0] m_mem [NW];
    bit            m_vld [NW];
    logic [7:0]    m_pend[$];

    function automatic void check(string name, string field, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s actual=%0h required=%0h", name, field, act, exp);
    endfunction

    function automatic void model_reset();
        m_mode  = 0;
        m_count = 0;
        m_err   = 0;
        foreach (m_vld[i]) m_vld[i] = 0;
        m_pend.delete();
    endfunction

    function automatic void model_step();
        logic [DW-1:0] w;
        if (i_reset) begin
            model_reset();
            return;
        end
        if (i_load_start) begin
            m_mode  = 1;
            m_count = 0;
            m_err   = 0;
            foreach (m_vld[i]) m_vld[i] = 0;
            m_pend.delete();
            return;
        end
        if (m_mode == 1 && i_load_valid) begin
            m_pend.push_back(i_load_byte);
            if (m_pend.size() == BPW) begin
                w = '0;
                for (int k = 0; k < BPW; k++) w = w | (DW'(m_pend[k]) << (8 * k));
                m_mem[m_count] = w;
                m_vld[m_count] = 1;
                m_count++;
                m_pend.delete();
                if (m_count == NW) m_mode = 2;
            end
        end
        if (m_mode != 0 && i_load_done) begin
            if (m_pend.size() != 0) m_err = 1;
            m_pend.delete();
            m_mode = 0;
        end
    endfunction

    function automatic exp_t expect_now(string name);
        exp_t e;
        bit   bad;
        bad      = (i_addr % BPW != 0) || (i_addr > DB - BPW);
        e.name   = name;
        e.fault  = i_read_en && bad;
        e.instr  = '0;
        if (i_read_en && m_mode == 0 && !bad) begin
            if (m_vld[i_addr / BPW]) e.instr = m_mem[i_addr / BPW];
        end
        e.count  = CW'(m_count);
        e.err    = m_err;
        e.full   = (m_mode == 2);
        e.busy   = (m_mode != 0);
        e.ready  = (m_mode == 1) && !i_load_start;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (chk) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow actual=empty required=entry");
            end else begin
                e = sb.pop_front();
                check(e.name, "instr", 64'(o_instruction), 64'(e.instr));
                check(e.name, "fault", 64'(o_fetch_fault), 64'(e.fault));
                check(e.name, "status", 64'({o_load_count, o_load_err, o_load_full, o_busy, o_load_ready}),
                      64'({e.count, e.err, e.full, e.busy, e.ready}));
            end
        end
    end

    task automatic cyc(string name, bit rst, bit st, bit v, logic [7:0] b, bit dn, bit rd, logic [AW-1:0] a);
        @(posedge clk);
        #1;
        i_reset      = rst;
        i_load_start = st;
        i_load_valid = v;
        i_load_byte  = b;
        i_load_done  = dn;
        i_read_en    = rd;
        i_addr       = a;
        if (rst) model_reset();
        chk = 1'b1;
        sb.push_back(expect_now(name));
        model_step();
    endtask

    task automatic fetch(string name, logic [AW-1:0] a);
        cyc(name, 0, 0, 0, 8'h00, 0, 1, a);
    endtask

    task automatic send(string name, logic [7:0] b);
        cyc(name, 0, 0, 1, b, 0, 1, 0);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return AW'($urandom_range(0, 31) * 4);
            1:       return AW'($urandom_range(0, NW - 1) * 4);
            2:       return AW'($urandom_range(0, DB - 1));
            3:       return AW'(DB - BPW);
            4:       return AW'(DB + $urandom_range(0, 64));
            default: return AW'($urandom());
        endcase
    endfunction

    initial begin
        logic [7:0] prog1 [8];
        int         len;
        prog1 = '{8'h13, 8'h00, 8'h20, 8'h00, 8'h93, 8'h00, 8'h30, 8'h00};
        i_reset = 1'b1; i_load_start = 0; i_load_valid = 0; i_load_byte = 0;
        i_load_done = 0; i_read_en = 0; i_addr = '0;
        model_reset();
        foreach (m_mem[i]) m_mem[i] = '0;

        cyc("reset", 1, 0, 0, 0, 0, 1, 0);
        cyc("reset", 1, 0, 0, 0, 0, 1, 0);
        fetch("post_reset", 0);

        cyc("start1", 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) send("prog1", prog1[i]);
        cyc("done1", 0, 0, 0, 0, 1, 1, 0);
        fetch("prog1_f0", 32'h0);
        fetch("prog1_f4", 32'h4);
        fetch("prog1_f8", 32'h8);
        fetch("fault_mis", 32'h2);
        fetch("fault_oor", 32'h400);
        cyc("rd_off", 0, 0, 0, 0, 0, 0, 32'h2);
        cyc("done_idle", 0, 0, 0, 0, 1, 1, 0);

        cyc("start2", 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) send("partial", 8'($urandom()));
        cyc("done2", 0, 0, 0, 0, 1, 1, 0);
        fetch("partial_f4", 32'h4);
        fetch("partial_f0", 32'h0);
        cyc("start3", 0, 1, 0, 0, 0, 1, 0);
        cyc("done3", 0, 0, 0, 0, 1, 1, 0);

        cyc("start4", 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) send("drop", 8'($urandom()));
        cyc("start_byte", 0, 1, 1, 8'hEE, 0, 1, 0);
        fetch("after_start", 32'h0);
        for (int i = 0; i < 3; i++) send("drop_w", 8'($urandom()));
        cyc("done_w_byte", 0, 0, 1, 8'hA5, 1, 1, 0);
        fetch("drop_f0", 32'h0);

        cyc("start5", 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) send("midload", 8'($urandom()));
        cyc("rst_mid", 1, 0, 0, 0, 0, 1, 0);
        cyc("rst_mid", 1, 0, 0, 0, 0, 1, 0);
        fetch("rst_f0", 32'h0);
        fetch("rst_f4", 32'h4);

        cyc("start_full", 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < DB; i++)
            cyc("stream", 0, 0, 1, 8'($urandom()), 0, $urandom_range(0, 1), rand_addr());
        send("byte_1025", 8'h77);
        cyc("done_full", 0, 0, 0, 0, 1, 1, 32'h3FC);
        fetch("full_f3fc", 32'h3FC);
        fetch("full_f0", 32'h0);
        fetch("full_f400", 32'h400);
        for (int i = 0; i < 16; i++) fetch("full_rand", rand_addr());

        for (int it = 0; it < 20; it++) begin
            cyc("rstart", 0, 1, $urandom_range(0, 1), 8'($urandom()), 0, 1, rand_addr());
            len = $urandom_range(0, 40);
            while (len > 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    cyc("rbyte", 0, 0, 1, 8'($urandom()), 0, $urandom_range(0, 1), rand_addr());
                    len--;
                end else begin
                    cyc("rgap", 0, 0, 0, 8'($urandom()), 0, $urandom_range(0, 1), rand_addr());
                end
            end
            cyc("rdone", 0, 0, $urandom_range(0, 1), 8'($urandom()), 1, 1, rand_addr());
            for (int k = 0; k < 12; k++)
                cyc("rfetch", 0, 0, 0, 0, 0, $urandom_range(0, 3) != 0, rand_addr());
        end

        @(posedge clk);
        #1;
        chk = 1'b0;
        i_read_en = 0; i_load_valid = 0; i_load_start = 0; i_load_done = 0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL sb_drain actual=%0d required=0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
